cash_data_reader: RTL and testbench
===================================

// Module: cash_data_reader
// PURPOSE
//   Read-side controller for the cash data-cell array. Accepts read requests over a
//   valid/ready handshake and returns data over a second valid/ready handshake.
//   Two request types: direct read of one cell by index, and key search, which scans
//   the parallel cell outputs. Sits between the hash-table lookup logic and the cell
//   array, opposite the write/delete path that drives we/del.
// PARAMETERS
//   DATA_WIDTH  32   width of one cell word
//   MEM_SIZE    128  number of cells; must equal the array's MEM_SIZE
//   KEY_WIDTH   16   key field width; the key is cell bits [KEY_WIDTH-1:0]
//   LANES       8    cells compared per cycle in SEARCH; 1..MEM_SIZE
//   IDX_W       $clog2(MEM_SIZE)  derived; not overridden
// PORTS
//   clk         in   1                    clock; all logic on the rising edge
//   reset       in   1                    synchronous reset, active-high
//   cells_in    in   [MEM_SIZE][DATA_WIDTH]  parallel data_out of the cell array
//   occupied    in   MEM_SIZE             per-cell valid flag from the write path
//   req_valid   in   1                    request present
//   req_ready   out  1                    request accepted when valid&&ready
//   req_op      in   1                    0=READ_IDX, 1=SEARCH_KEY
//   req_index   in   IDX_W                cell index for READ_IDX
//   req_key     in   KEY_WIDTH            key for SEARCH_KEY
//   resp_valid  out  1                    response present
//   resp_ready  in   1                    response consumed when valid&&ready
//   resp_hit    out  1                    READ: index in range && occupied; SEARCH: match
//   resp_index  out  IDX_W                READ: echoed index; SEARCH: lowest matching index
//   resp_data   out  DATA_WIDTH           cell word on hit, else 0
//   busy        out  1                    high in any state other than IDLE
// BEHAVIOUR
//   - Reset values: state=IDLE; req_ready=1; resp_valid=0, resp_hit=0, resp_index=0,
//     resp_data=0; busy=0. Reset wins over every other event in the same cycle.
//   - FSM states: IDLE, SCAN, RESP. req_ready = (state==IDLE). Nothing is queued.
//   - IDLE + accept READ_IDX: cells_in[req_index] and occupied are sampled that cycle.
//     Next state is RESP, so resp_valid is high on the following cycle (latency 1).
//     If req_index >= MEM_SIZE or the cell is not occupied: hit=0, data=0, index echoed.
//   - IDLE + accept SEARCH_KEY: the key is latched, base=0, next state SCAN.
//   - SCAN: each cycle compares cells base..base+LANES-1. A lane matches when
//     occupied && cell[KEY_WIDTH-1:0]==key. Lanes at index >= MEM_SIZE are masked.
//     On any match, the lowest matching lane is registered into resp_*, hit=1, and the
//     next state is RESP (early exit). If there is no match and this is the last group
//     (base+LANES >= MEM_SIZE), hit=0, data=0, index=0, and the next state is RESP.
//     Otherwise base += LANES.
//     Worst case: ceil(MEM_SIZE/LANES) SCAN cycles, then 1 cycle to resp_valid.
//   - The scan reads live cell values. A cell changed after its group was compared is
//     not revisited; a cell changed before its group is compared is seen. No stall.
//   - RESP: resp_* are held stable while resp_valid && !resp_ready. On a handshake the
//     next state is IDLE, resp_valid drops the next cycle, and req_ready rises the next
//     cycle. There is no same-cycle turnaround.
//   - resp_valid never depends combinationally on resp_ready. req_ready never depends
//     on req_valid.
//   - Reset asserted in SCAN or RESP: the FSM aborts to IDLE next cycle and the pending
//     response is discarded (never presented).
//   - base counter width is IDX_W+1 to avoid wrap when MEM_SIZE is a power of two.
// STRUCTURE
//   - cash_pkg: typedef enum {READ_IDX, SEARCH_KEY} cash_op_t; typedef enum
//     {IDLE, SCAN, RESP} cash_rd_state_t. Shared with the write-path controller.
//   - Sub-module cash_lane_match #(DATA_WIDTH, KEY_WIDTH, LANES): combinational lane
//     compare plus lowest-index priority encoder; outputs any_hit, hit_lane, hit_data.
//   - Top level: FSM, base counter, response registers, READ_IDX mux.
// TESTING
//   - After reset, check req_ready=1, resp_valid=0, busy=0, then READ_IDX idx=5 with
//     occupied[5]=1 and cell5=0xDEAD_0042. Expect resp_valid 1 cycle after accept, hit=1,
//     data=0xDEAD_0042, index=5.
//   - READ_IDX idx=7 with occupied[7]=0. Expect hit=0, data=0, index=7.
//   - SEARCH key=0x0042 with matches at cells 17 and 90, LANES=8. Expect hit=1, index=17,
//     resp_valid after 3 SCAN cycles plus 1.
//   - SEARCH key=0xBEEF with no match in MEM_SIZE=128, LANES=8. Expect 16 SCAN cycles,
//     then hit=0, data=0, index=0.
//   - MEM_SIZE=10, LANES=4, match at cell 9 and junk in masked lanes 10-11. Expect hit=1,
//     index=9, and no false hits.
//   - Hold resp_ready=0 for 5 cycles: resp_* stable and req_ready=0. Assert reset mid-SCAN:
//     IDLE next cycle and no response is emitted.

Source files
------------

// File: rtl/cash_pkg.sv
// Shared types for the cash data-cell read and write controllers.
// Holds the request opcode, the read FSM states and a lane-index width helper.
package cash_pkg;

    typedef enum logic {
        READ_IDX   = 1'b0,
        SEARCH_KEY = 1'b1
    } cash_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        RESP = 2'd2
    } cash_rd_state_t;

    // A single lane still needs a one-bit select so ports never collapse to zero width.
    function automatic int lane_idx_w(input int lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

endpackage

// File: rtl/cash_lane_match.sv
// Combinational key compare across LANES cells with lowest-lane priority select.
// Zero latency; no flow control, the caller decides when the result is used.
module cash_lane_match
    import cash_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int KEY_WIDTH  = 16,
    parameter int LANES      = 8,
    parameter int LW         = lane_idx_w(LANES)
) (
    input  logic [LANES-1:0][DATA_WIDTH-1:0] lane_cells,
    input  logic [LANES-1:0]                 lane_ok,
    input  logic [KEY_WIDTH-1:0]             key,
    output logic                             any_hit,
    output logic [LW-1:0]                    hit_lane,
    output logic [DATA_WIDTH-1:0]            hit_data
);

    // Walk from the top lane down so the lowest matching lane is the last writer.
    always_comb begin
        any_hit  = 1'b0;
        hit_lane = '0;
        hit_data = '0;
        for (int l = LANES - 1; l >= 0; l--) begin
            if (lane_ok[l] && (lane_cells[l][KEY_WIDTH-1:0] == key)) begin
                any_hit  = 1'b1;
                hit_lane = LW'(l);
                hit_data = lane_cells[l];
            end
        end
    end

endmodule

// File: rtl/cash_data_reader.sv
// Read controller for the cash cell array: direct index read (1 cycle) or LANES-wide key scan.
// One request in flight; req_ready only in IDLE, response held until resp_ready.
module cash_data_reader
    import cash_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_SIZE   = 128,
    parameter int KEY_WIDTH  = 16,
    parameter int LANES      = 8,
    parameter int IDX_W      = $clog2(MEM_SIZE)
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [MEM_SIZE-1:0][DATA_WIDTH-1:0] cells_in,
    input  logic [MEM_SIZE-1:0]                 occupied,
    input  logic                                req_valid,
    output logic                                req_ready,
    input  logic                                req_op,
    input  logic [IDX_W-1:0]                    req_index,
    input  logic [KEY_WIDTH-1:0]                req_key,
    output logic                                resp_valid,
    input  logic                                resp_ready,
    output logic                                resp_hit,
    output logic [IDX_W-1:0]                    resp_index,
    output logic [DATA_WIDTH-1:0]               resp_data,
    output logic                                busy
);

    localparam int LW    = lane_idx_w(LANES);
    localparam int SUM_W = $clog2(MEM_SIZE + LANES) + 1;
    localparam logic [SUM_W-1:0] MEM_SIZE_S = SUM_W'(MEM_SIZE);
    localparam logic [SUM_W-1:0] LANES_S    = SUM_W'(LANES);

    cash_rd_state_t state_q, state_d;
    logic [IDX_W:0]          base_q, base_d;
    logic [KEY_WIDTH-1:0]    key_q, key_d;
    logic                    resp_hit_q, resp_hit_d;
    logic [IDX_W-1:0]        resp_index_q, resp_index_d;
    logic [DATA_WIDTH-1:0]   resp_data_q, resp_data_d;

    logic [LANES-1:0][SUM_W-1:0]      lane_idx;
    logic [LANES-1:0][DATA_WIDTH-1:0] lane_cells;
    logic [LANES-1:0]                 lane_ok;
    logic                             any_hit;
    logic [LW-1:0]                    hit_lane;
    logic [DATA_WIDTH-1:0]            hit_data;
    logic [SUM_W-1:0]                 base_next;
    logic                             last_group;
    logic                             rd_in_range;

    // Lanes past the end of the array read as empty so they can never match.
    always_comb begin
        lane_idx   = '0;
        lane_cells = '0;
        lane_ok    = '0;
        for (int l = 0; l < LANES; l++) begin
            lane_idx[l] = SUM_W'(base_q) + SUM_W'(l);
            if (lane_idx[l] < MEM_SIZE_S) begin
                lane_cells[l] = cells_in[lane_idx[l][IDX_W-1:0]];
                lane_ok[l]    = occupied[lane_idx[l][IDX_W-1:0]];
            end
        end
    end

    cash_lane_match #(
        .DATA_WIDTH (DATA_WIDTH),
        .KEY_WIDTH  (KEY_WIDTH),
        .LANES      (LANES),
        .LW         (LW)
    ) u_lane_match (
        .lane_cells (lane_cells),
        .lane_ok    (lane_ok),
        .key        (key_q),
        .any_hit    (any_hit),
        .hit_lane   (hit_lane),
        .hit_data   (hit_data)
    );

    assign base_next   = SUM_W'(base_q) + LANES_S;
    assign last_group  = (base_next >= MEM_SIZE_S);
    assign rd_in_range = (SUM_W'(req_index) < MEM_SIZE_S);

    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        key_d        = key_q;
        resp_hit_d   = resp_hit_q;
        resp_index_d = resp_index_q;
        resp_data_d  = resp_data_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (cash_op_t'(req_op) == SEARCH_KEY) begin
                        key_d   = req_key;
                        base_d  = '0;
                        state_d = SCAN;
                    end else begin
                        resp_index_d = req_index;
                        resp_hit_d   = 1'b0;
                        resp_data_d  = '0;
                        if (rd_in_range && occupied[req_index]) begin
                            resp_hit_d  = 1'b1;
                            resp_data_d = cells_in[req_index];
                        end
                        state_d = RESP;
                    end
                end
            end
            SCAN: begin
                if (any_hit) begin
                    resp_hit_d   = 1'b1;
                    resp_index_d = IDX_W'(base_q) + IDX_W'(hit_lane);
                    resp_data_d  = hit_data;
                    state_d      = RESP;
                end else if (last_group) begin
                    resp_hit_d   = 1'b0;
                    resp_index_d = '0;
                    resp_data_d  = '0;
                    state_d      = RESP;
                end else begin
                    base_d = base_next[IDX_W:0];
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            base_q       <= '0;
            key_q        <= '0;
            resp_hit_q   <= 1'b0;
            resp_index_q <= '0;
            resp_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            key_q        <= key_d;
            resp_hit_q   <= resp_hit_d;
            resp_index_q <= resp_index_d;
            resp_data_q  <= resp_data_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign busy       = (state_q != IDLE);
    assign resp_hit   = resp_hit_q;
    assign resp_index = resp_index_q;
    assign resp_data  = resp_data_q;

endmodule

// File: tb/tb_cash_data_reader.sv
// Directed bench for cash_data_reader: a 128x8 instance for the main table and a 10x4
// instance for masked-lane corners, plus backpressure and mid-scan reset sequences.
module tb_cash_data_reader;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [127:0][31:0] a_cells;
    logic [127:0]       a_occ;
    logic               a_req_valid = 1'b0, a_req_op = 1'b0, a_resp_ready = 1'b0;
    logic [6:0]         a_req_index = '0;
    logic [15:0]        a_req_key = '0;
    logic               a_req_ready, a_resp_valid, a_resp_hit, a_busy;
    logic [6:0]         a_resp_index;
    logic [31:0]        a_resp_data;

    logic [9:0][31:0]   b_cells;
    logic [9:0]         b_occ;
    logic               b_req_valid = 1'b0, b_req_op = 1'b0, b_resp_ready = 1'b0;
    logic [3:0]         b_req_index = '0;
    logic [15:0]        b_req_key = '0;
    logic               b_req_ready, b_resp_valid, b_resp_hit, b_busy;
    logic [3:0]         b_resp_index;
    logic [31:0]        b_resp_data;

    cash_data_reader #(.DATA_WIDTH(32), .MEM_SIZE(128), .KEY_WIDTH(16), .LANES(8)) u_a (
        .clk(clk), .reset(reset), .cells_in(a_cells), .occupied(a_occ),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_op(a_req_op),
        .req_index(a_req_index), .req_key(a_req_key), .resp_valid(a_resp_valid),
        .resp_ready(a_resp_ready), .resp_hit(a_resp_hit), .resp_index(a_resp_index),
        .resp_data(a_resp_data), .busy(a_busy)
    );

    cash_data_reader #(.DATA_WIDTH(32), .MEM_SIZE(10), .KEY_WIDTH(16), .LANES(4)) u_b (
        .clk(clk), .reset(reset), .cells_in(b_cells), .occupied(b_occ),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_op(b_req_op),
        .req_index(b_req_index), .req_key(b_req_key), .resp_valid(b_resp_valid),
        .resp_ready(b_resp_ready), .resp_hit(b_resp_hit), .resp_index(b_resp_index),
        .resp_data(b_resp_data), .busy(b_busy)
    );

    typedef struct {
        logic        op;
        logic [7:0]  idx;
        logic [15:0] key;
        logic        hit;
        logic [7:0]  rindex;
        logic [31:0] data;
        int          lat;
    } vec_t;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Latency counts clock edges from the accepting edge to the edge that raises resp_valid.
    task automatic run_req(input bit sel, input logic op, input logic [7:0] idx,
                           input logic [15:0] key, output logic hit,
                           output logic [7:0] rix, output logic [31:0] rdata, output int lat);
        @(negedge clk);
        if (!sel) begin
            a_req_valid = 1'b1; a_req_op = op; a_req_index = idx[6:0]; a_req_key = key;
        end else begin
            b_req_valid = 1'b1; b_req_op = op; b_req_index = idx[3:0]; b_req_key = key;
        end
        @(negedge clk);
        a_req_valid = 1'b0;
        b_req_valid = 1'b0;
        lat = 1;
        while (!(sel ? b_resp_valid : a_resp_valid) && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        hit   = sel ? b_resp_hit : a_resp_hit;
        rix   = sel ? {4'h0, b_resp_index} : {1'b0, a_resp_index};
        rdata = sel ? b_resp_data : a_resp_data;
        if (!sel) a_resp_ready = 1'b1; else b_resp_ready = 1'b1;
        @(negedge clk);
        a_resp_ready = 1'b0;
        b_resp_ready = 1'b0;
    endtask

    task automatic apply(input bit sel, input string tag, input vec_t v);
        logic        hit;
        logic [7:0]  rix;
        logic [31:0] rdata;
        int          lat;
        run_req(sel, v.op, v.idx, v.key, hit, rix, rdata, lat);
        check({tag, " hit"},   32'(hit),   32'(v.hit));
        check({tag, " index"}, 32'(rix),   32'(v.rindex));
        check({tag, " data"},  rdata,      v.data);
        check({tag, " lat"},   32'(lat),   32'(v.lat));
    endtask

    vec_t vecs_a[10];
    vec_t vecs_b[4];
    vec_t v_seq;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic seen;
        for (int i = 0; i < 128; i++) a_cells[i] = {8'hA0, 8'(i), 16'h0100 + 16'(i)};
        a_cells[5]  = 32'hDEAD_0042;
        a_cells[17] = 32'h1111_0042;
        a_cells[90] = 32'h2222_0042;
        a_occ = '1;
        a_occ[7]  = 1'b0;
        a_occ[40] = 1'b0;

        b_cells    = '0;
        b_cells[3] = 32'h7777_0033;
        b_cells[9] = 32'h5555_0033;
        b_occ      = 10'b10_0000_0000;

        //           op    idx     key       hit   rindex  data          lat
        vecs_a[0] = '{1'b0, 8'd5,   16'h0,    1'b1, 8'd5,   32'hDEAD_0042, 1};
        vecs_a[1] = '{1'b0, 8'd7,   16'h0,    1'b0, 8'd7,   32'h0,         1};
        vecs_a[2] = '{1'b0, 8'd0,   16'h0,    1'b1, 8'd0,   32'hA000_0100, 1};
        vecs_a[3] = '{1'b0, 8'd127, 16'h0,    1'b1, 8'd127, 32'hA07F_017F, 1};
        vecs_a[4] = '{1'b1, 8'd0,   16'h0042, 1'b1, 8'd5,   32'hDEAD_0042, 2};
        vecs_a[5] = '{1'b1, 8'd0,   16'hBEEF, 1'b0, 8'd0,   32'h0,         17};
        vecs_a[6] = '{1'b1, 8'd0,   16'h0107, 1'b0, 8'd0,   32'h0,         17};
        vecs_a[7] = '{1'b1, 8'd0,   16'h017F, 1'b1, 8'd127, 32'hA07F_017F, 17};
        vecs_a[8] = '{1'b1, 8'd0,   16'h0108, 1'b1, 8'd8,   32'hA008_0108, 3};
        vecs_a[9] = '{1'b0, 8'd40,  16'h0,    1'b0, 8'd40,  32'h0,         1};

        vecs_b[0] = '{1'b1, 8'd0,   16'h0033, 1'b1, 8'd9,   32'h5555_0033, 4};
        vecs_b[1] = '{1'b1, 8'd0,   16'h0000, 1'b0, 8'd0,   32'h0,         4};
        vecs_b[2] = '{1'b0, 8'd12,  16'h0,    1'b0, 8'd12,  32'h0,         1};
        vecs_b[3] = '{1'b0, 8'd9,   16'h0,    1'b1, 8'd9,   32'h5555_0033, 1};

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset req_ready",  32'(a_req_ready),  32'd1);
        check("reset resp_valid", 32'(a_resp_valid), 32'd0);
        check("reset busy",       32'(a_busy),       32'd0);
        check("reset resp_hit",   32'(a_resp_hit),   32'd0);
        check("reset resp_index", 32'(a_resp_index), 32'd0);
        check("reset resp_data",  a_resp_data,       32'd0);

        for (int i = 0; i < 10; i++) apply(1'b0, $sformatf("a%0d", i), vecs_a[i]);
        for (int i = 0; i < 4; i++)  apply(1'b1, $sformatf("b%0d", i), vecs_b[i]);

        // Cell 5 vacated: the key search must fall through to the group holding cell 17.
        a_occ[5] = 1'b0;
        v_seq = '{1'b1, 8'd0, 16'h0042, 1'b1, 8'd17, 32'h1111_0042, 4};
        apply(1'b0, "search17", v_seq);
        a_occ[5] = 1'b1;

        // Response held under backpressure while the source cell and request pins change.
        @(negedge clk);
        a_req_valid = 1'b1; a_req_op = 1'b0; a_req_index = 7'd5;
        @(negedge clk);
        a_req_op = 1'b1; a_req_key = 16'h0108;
        a_cells[5] = 32'h0BAD_F00D;
        for (int c = 0; c < 5; c++) begin
            check($sformatf("hold%0d resp_valid", c), 32'(a_resp_valid), 32'd1);
            check($sformatf("hold%0d resp_data", c),  a_resp_data,       32'hDEAD_0042);
            check($sformatf("hold%0d req_ready", c),  32'(a_req_ready),  32'd0);
            @(negedge clk);
        end
        a_req_valid = 1'b0;
        a_resp_ready = 1'b1;
        @(negedge clk);
        a_resp_ready = 1'b0;
        check("release resp_valid", 32'(a_resp_valid), 32'd0);
        check("release req_ready",  32'(a_req_ready),  32'd1);
        check("release busy",       32'(a_busy),       32'd0);
        a_cells[5] = 32'hDEAD_0042;

        // Reset mid-scan drops the search without ever presenting a response.
        @(negedge clk);
        a_req_valid = 1'b1; a_req_op = 1'b1; a_req_key = 16'hBEEF;
        @(negedge clk);
        a_req_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("scan busy", 32'(a_busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort busy",       32'(a_busy),       32'd0);
        check("abort req_ready",  32'(a_req_ready),  32'd1);
        check("abort resp_valid", 32'(a_resp_valid), 32'd0);
        seen = 1'b0;
        a_resp_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (a_resp_valid) seen = 1'b1;
        end
        a_resp_ready = 1'b0;
        check("abort no response", 32'(seen), 32'd0);

        // The instance must still serve requests normally after the abort.
        apply(1'b0, "post_abort", vecs_a[8]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
